// File: rtl/fifo_pkg.sv
// Shared FIFO constants and sizing helpers, also used by the operand loaders.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_NUM_CH     = 4;

   // Level counter must represent 0..DEPTH inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_channel.sv
// One first-word-fall-through channel: storage, wrap-by-compare pointers, level and flags.
module fifo_channel
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_DEPTH,
   parameter  int AF_MARGIN  = 2,
   parameter  int AE_MARGIN  = 2,
   localparam int CNT_W      = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      level,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - AF_MARGIN);
   localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_MARGIN);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   if (DEPTH < 2 || AF_MARGIN >= DEPTH || AE_MARGIN >= DEPTH) begin : g_bad_param
      $error("fifo_channel: illegal DEPTH/AF_MARGIN/AE_MARGIN combination");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic                  push, pop;

   // Explicit wrap so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Handshake decode depends on registered level only: no in->out comb paths.
   assign in_ready     = (level != FULL_LVL);
   assign out_valid    = (level != '0);
   assign almost_full  = (level >= AF_LVL);
   assign almost_empty = (level <= AE_LVL);
   assign out_data     = out_valid ? mem[rd_ptr] : '0;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage is intentionally not reset; level gates visibility.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/fifo_bank_fwft.sv
// Bank of NUM_CH independent FWFT FIFOs, one per systolic array edge row/column.
module fifo_bank_fwft
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_DEPTH,
   parameter  int NUM_CH     = DEF_NUM_CH,
   parameter  int AF_MARGIN  = 2,
   parameter  int AE_MARGIN  = 2,
   localparam int CNT_W      = cnt_width(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            flush,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH*CNT_W-1:0]      level,
   output logic [NUM_CH-1:0]            almost_full,
   output logic [NUM_CH-1:0]            almost_empty
);

   logic [NUM_CH-1:0][DATA_WIDTH-1:0] in_data_a, out_data_a;
   logic [NUM_CH-1:0][CNT_W-1:0]      level_a;

   // Packed 2-D views share bit order with the flat buses: channel i at [i*W +: W].
   assign in_data_a = in_data;
   assign out_data  = out_data_a;
   assign level     = level_a;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fifo_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .AF_MARGIN  (AF_MARGIN),
         .AE_MARGIN  (AE_MARGIN)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .flush        (flush[i]),
         .in_valid     (in_valid[i]),
         .in_ready     (in_ready[i]),
         .in_data      (in_data_a[i]),
         .out_valid    (out_valid[i]),
         .out_ready    (out_ready[i]),
         .out_data     (out_data_a[i]),
         .level        (level_a[i]),
         .almost_full  (almost_full[i]),
         .almost_empty (almost_empty[i])
      );
   end

endmodule

// File: tb/tb_fifo_bank_fwft.sv
// Scoreboard bench for fifo_bank_fwft: directed scenarios plus randomized traffic.
module tb_fifo_bank_fwft;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int NCH   = 2;
   localparam int CW    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    flush = '0;
   logic [NCH-1:0]    in_valid = '0;
   logic [NCH-1:0]    in_ready;
   logic [NCH*DW-1:0] in_data = '0;
   logic [NCH-1:0]    out_valid;
   logic [NCH-1:0]    out_ready = '0;
   logic [NCH*DW-1:0] out_data;
   logic [NCH*CW-1:0] level;
   logic [NCH-1:0]    almost_full;
   logic [NCH-1:0]    almost_empty;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] mq [NCH][$];   // expected contents per channel, head at index 0

   fifo_bank_fwft #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .AF_MARGIN(1), .AE_MARGIN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int c, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s ch%0d @%0t: got %0d (0x%0h) want %0d (0x%0h)", nm, c, $time, act, act, exp, exp);
      end
   endtask

   function automatic int lvl(input int c);
      return int'(level[c*CW +: CW]);
   endfunction

   function automatic int odat(input int c);
      return int'(out_data[c*DW +: DW]);
   endfunction

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int c, input logic v, input logic [DW-1:0] d, input logic r);
      in_valid[c]          = v;
      in_data[c*DW +: DW]  = d;
      out_ready[c]         = r;
   endtask

   // Monitor: mid-cycle, compare DUT against the queue model, then apply this cycle's transfers.
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         int n;
         n = mq[c].size();
         if (!rst_n) begin
            chk("rst_level", c, lvl(c), 0);
            chk("rst_in_ready", c, int'(in_ready[c]), 1);
            chk("rst_out_valid", c, int'(out_valid[c]), 0);
            chk("rst_out_data", c, odat(c), 0);
            chk("rst_ae", c, int'(almost_empty[c]), 1);
            chk("rst_af", c, int'(almost_full[c]), 0);
            mq[c].delete();
         end else begin
            chk("level", c, lvl(c), n);
            chk("in_ready", c, int'(in_ready[c]), int'(n != DEPTH));
            chk("out_valid", c, int'(out_valid[c]), int'(n != 0));
            chk("almost_full", c, int'(almost_full[c]), int'(n >= DEPTH - 1));
            chk("almost_empty", c, int'(almost_empty[c]), int'(n <= 1));
            chk("out_data", c, odat(c), (n != 0) ? int'(mq[c][0]) : 0);
            if (flush[c]) mq[c].delete();
            else begin
               if (out_ready[c] && n != 0) void'(mq[c].pop_front());
               if (in_valid[c] && n != DEPTH) mq[c].push_back(in_data[c*DW +: DW]);
            end
         end
      end
   end

   task automatic drain(input int c);
      int k;
      drive(c, 1'b0, '0, 1'b1);
      k = 0;
      while (lvl(c) != 0 && k < 20) begin
         cyc();
         k++;
      end
      chk("drain_empty", c, lvl(c), 0);
      out_ready[c] = 1'b0;
   endtask

   initial begin
      cyc(3);
      rst_n = 1'b1;
      cyc();

      // 1: fill ch0
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, DW'(8'h11 * (i + 1)), 1'b0);
         cyc();
         chk("fill_level", 0, lvl(0), i + 1);
         chk("fill_head", 0, odat(0), 8'h11);
      end
      chk("af_at_full", 0, int'(almost_full[0]), 1);
      drive(0, 1'b1, 8'h55, 1'b0);
      cyc();
      chk("refused_level", 0, lvl(0), 4);
      chk("refused_ready", 0, int'(in_ready[0]), 0);

      // 2: full, stream through with pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'b1, DW'(8'hA0 + i), 1'b1);
         cyc();
      end
      drain(0);

      // 3: steady level 2 with simultaneous push/pop
      drive(0, 1'b1, 8'h30, 1'b0); cyc();
      drive(0, 1'b1, 8'h31, 1'b0); cyc();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1'b1, DW'(8'h32 + i), 1'b1);
         cyc();
         chk("steady_level", 0, lvl(0), 2);
         chk("steady_head", 0, odat(0), 8'h31 + i);
      end
      drain(0);

      // 4: flush full ch0 while pushing and popping; ch1 must not move
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, DW'(8'h60 + i), 1'b0);
         drive(1, i < 2, DW'(8'h70 + i), 1'b0);
         cyc();
      end
      drive(1, 1'b0, '0, 1'b0);
      drive(0, 1'b1, 8'hEE, 1'b1);
      flush[0] = 1'b1;
      cyc();
      flush[0] = 1'b0;
      drive(0, 1'b0, '0, 1'b0);
      chk("flush_level", 0, lvl(0), 0);
      chk("flush_valid", 0, int'(out_valid[0]), 0);
      chk("flush_data", 0, odat(0), 0);
      chk("flush_ae", 0, int'(almost_empty[0]), 1);
      chk("flush_other_level", 1, lvl(1), 2);
      chk("flush_other_head", 1, odat(1), 8'h70);
      drain(1);

      // 5: async reset with both channels at level 3
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, DW'(8'h80 + i), 1'b0);
         drive(1, 1'b1, DW'(8'h90 + i), 1'b0);
         cyc();
      end
      drive(0, 1'b0, '0, 1'b0);
      drive(1, 1'b0, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk("async_rst_level", c, lvl(c), 0);
         chk("async_rst_valid", c, int'(out_valid[c]), 0);
         chk("async_rst_ready", c, int'(in_ready[c]), 1);
         mq[c].delete();
      end
      cyc();
      rst_n = 1'b1;
      drive(0, 1'b1, 8'h5A, 1'b0);
      cyc();
      drive(0, 1'b0, '0, 1'b0);
      chk("post_rst_valid", 0, int'(out_valid[0]), 1);
      chk("post_rst_data", 0, odat(0), 8'h5A);
      drain(0);

      // 6: random traffic with rare flushes
      for (int i = 0; i < 2000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            drive(c, 1'($urandom_range(1)), DW'($urandom), 1'($urandom_range(1)));
            flush[c] = ($urandom_range(63) == 0);
         end
         cyc();
      end
      flush = '0;
      for (int c = 0; c < NCH; c++) drain(c);
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
